// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART access controller: FSM states, UART register map, status bits.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_POLL,
        ST_PWAIT,
        ST_XFER,
        ST_XWAIT,
        ST_DONE
    } state_t;

    localparam logic [31:0] ADDR_RX   = 32'h0;
    localparam logic [31:0] ADDR_TX   = 32'h4;
    localparam logic [31:0] ADDR_STAT = 32'h8;
    localparam logic [31:0] ADDR_CTRL = 32'hC;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_RX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_TX_FULL  = 3;

    localparam logic [31:0] CTRL_CLR_MASK = 32'h3;
    localparam logic [3:0]  WE_ALL        = 4'hF;

    // A tx needs room in the tx FIFO; an rx needs a byte waiting.
    function automatic logic uart_ready(input logic is_tx, input logic [31:0] stat);
        return is_tx ? !stat[STAT_TX_FULL] : stat[STAT_RX_VALID];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves on upd.
// Zero latency; ties go to the requester not granted last (core after reset).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic [1:0] gnt
);

    logic last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (upd) begin
            last_q <= upd_idx;
        end
    end

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/uart_access_ctrl.sv
// Shares a polled UART register port between core (bit0) and loader (bit1).
// Latency req->ack 3+2*RD_LAT cycles when ready; requesters hold req until their one-cycle ack.
// Not-ready status is re-polled up to POLL_LIMIT times, then the transaction ends with tout.
module uart_access_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int POLL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  op,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic [1:0]  ack,
    output logic [7:0]  rdata,
    output logic        tout,
    output logic        busy,
    output logic [31:0] uart_addr,
    output logic [31:0] uart_din,
    output logic        uart_en,
    output logic [3:0]  uart_we,
    input  logic [31:0] uart_dout,
    input  logic        uart_err,
    output logic        err_o
);

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [7:0]  poll_q, poll_d;
    logic        gidx_q, gidx_d;
    logic        op_q, op_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        tout_q, tout_d;
    logic        err_q;

    logic [1:0]  gnt;
    logic        bus_en;
    logic [31:0] bus_addr, bus_din;
    logic [3:0]  bus_we;
    logic        wait_last;
    logic [8:0]  poll_next;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .upd     (state_q == ST_DONE),
        .upd_idx (gidx_q),
        .gnt     (gnt)
    );

    assign wait_last = (wcnt_q == 8'(RD_LAT - 1));
    assign poll_next = {1'b0, poll_q} + 9'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            wcnt_q  <= '0;
            poll_q  <= '0;
            gidx_q  <= 1'b0;
            op_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            poll_q  <= poll_d;
            gidx_q  <= gidx_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tout_q  <= tout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (uart_err) begin
            err_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        poll_d   = poll_q;
        gidx_d   = gidx_q;
        op_d     = op_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        tout_d   = tout_q;
        bus_en   = 1'b0;
        bus_addr = '0;
        bus_din  = '0;
        bus_we   = '0;
        ack      = 2'b00;

        case (state_q)
            ST_INIT: begin
                bus_en   = 1'b1;
                bus_addr = ADDR_CTRL;
                bus_din  = CTRL_CLR_MASK;
                bus_we   = WE_ALL;
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                if (|req) begin
                    gidx_d  = gnt[1];
                    op_d    = gnt[1] ? op[1] : op[0];
                    wdata_d = gnt[1] ? wdata1 : wdata0;
                    poll_d  = '0;
                    rdata_d = '0;
                    tout_d  = 1'b0;
                    state_d = ST_POLL;
                end
            end
            ST_POLL: begin
                bus_en   = 1'b1;
                bus_addr = ADDR_STAT;
                wcnt_d   = '0;
                state_d  = ST_PWAIT;
            end
            ST_PWAIT: begin
                if (!wait_last) begin
                    wcnt_d = wcnt_q + 8'd1;
                end else if (uart_ready(op_q, uart_dout)) begin
                    state_d = ST_XFER;
                end else begin
                    poll_d = poll_next[7:0];
                    if (poll_next == 9'(POLL_LIMIT)) begin
                        tout_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_POLL;
                    end
                end
            end
            ST_XFER: begin
                bus_en = 1'b1;
                if (op_q) begin
                    bus_addr = ADDR_TX;
                    bus_din  = {24'h0, wdata_q};
                    bus_we   = WE_ALL;
                end else begin
                    bus_addr = ADDR_RX;
                end
                wcnt_d  = '0;
                state_d = ST_XWAIT;
            end
            ST_XWAIT: begin
                if (!wait_last) begin
                    wcnt_d = wcnt_q + 8'd1;
                end else begin
                    if (!op_q) begin
                        rdata_d = uart_dout[7:0];
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ack     = gidx_q ? 2'b10 : 2'b01;
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // The bus stays quiet while reset is held, even though the state already reads INIT.
    assign uart_en   = bus_en & ~rst;
    assign uart_addr = rst ? 32'h0 : bus_addr;
    assign uart_din  = rst ? 32'h0 : bus_din;
    assign uart_we   = rst ? 4'h0 : bus_we;

    assign rdata = rdata_q;
    assign tout  = tout_q;
    assign busy  = (state_q != ST_IDLE);
    assign err_o = err_q;

endmodule

// File: doc/uart_access_ctrl.md
UART_ACCESS_CTRL -- requirements
Module: uart_access_ctrl

Interface
REQ-001 Parameter RD_LAT, 2, cycles from UART en-cycle to valid uart_dout.
REQ-002 Parameter POLL_LIMIT, 255, max status polls per transaction before timeout (8-bit).
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 req  in  2  per-requester request (bit0 = core, bit1 = loader), held until ack.
REQ-006 op  in  2  per-requester operation: 0 = rx byte read, 1 = tx byte write.
REQ-007 wdata0, wdata1  in  8 each  tx byte per requester.
REQ-008 ack  out  2  one-cycle completion pulse to the granted requester.
REQ-009 rdata  out  8  rx byte, valid in ack cycle; 0 for tx.
REQ-010 tout  out  1  valid in ack cycle; 1 = poll limit hit, no transfer performed.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 uart_addr  out  32; uart_din  out  32; uart_en  out  1; uart_we  out  4: UART bus master.
REQ-013 uart_dout  in  32; uart_err  in  1: UART read data and error.
REQ-014 err_o  out  1  sticky copy of uart_err.

Function
REQ-015 UART map: 0x0 rx pop, 0x4 tx push, 0x8 stat {tx_full[3], tx_empty[2], rx_full[1], rx_valid[0]}, 0xC ctrl (din[0] clear tx, din[1] clear rx).
REQ-016 States: INIT, IDLE, POLL, PWAIT, XFER, XWAIT, DONE.
REQ-017 INIT: single cycle, en=1, addr=0xC, din=0x3, we=0xF; next IDLE.
REQ-018 IDLE: any req bit set -> grant, latch op and wdata of grantee, clear poll count, next POLL.
REQ-019 Arbitration round-robin: single request wins; both set -> requester not granted last; last-grant pointer resets to 1 (core wins first tie).
REQ-020 Grant, latched op and wdata fixed until DONE; req changes mid-transaction ignored; req dropped before ack does not abort.
REQ-021 POLL: one cycle, en=1, addr=0x8, we=0; next PWAIT.
REQ-022 PWAIT: RD_LAT cycles; last cycle samples uart_dout: ready = op ? !dout[3] : dout[0].
REQ-023 Ready -> XFER; not ready -> poll count +1; count == POLL_LIMIT -> DONE with tout=1; else -> POLL.
REQ-024 XFER: one cycle, en=1; tx: addr=0x4, din={24'b0,wdata}, we=0xF; rx: addr=0x0, din=0, we=0; next XWAIT.
REQ-025 XWAIT: RD_LAT cycles; rx captures uart_dout[7:0] into rdata on last cycle; next DONE.
REQ-026 DONE: ack[grant]=1 exactly one cycle, rdata/tout valid; next IDLE; update last-grant pointer.
REQ-027 uart_en high only in INIT/POLL/XFER; addr, din, we zero when en low.
REQ-028 Latency, no waiting: req seen in IDLE cycle 0 -> ack in cycle 3+2*RD_LAT (7 at default).
REQ-029 New request accepted in cycle after ack; no back-to-back ack to same requester without IDLE.
REQ-030 err_o set on any cycle uart_err=1; cleared only by reset.

Reset
REQ-031 Reset state INIT; ack=0, rdata=0, tout=0, busy=1 until IDLE, err_o=0, uart_en=0, uart_addr/din/we=0, poll count=0.
REQ-032 Reset mid-transaction aborts silently: no ack, latched request discarded, INIT re-clears FIFOs.

Structure
REQ-033 Package uart_ctrl_pkg: state encoding, UART address constants, stat bit indices, ctrl clear mask 0x3.
REQ-034 Sub-module rr_arb2: 2-way round-robin arbiter (req, update strobe -> one-hot grant), instantiated once.

Verification
REQ-035 Reset release -> one cycle en=1, addr=0xC, din=0x3, we=0xF, then busy=0.
REQ-036 Core tx 0x41, UART not full -> stat read, write addr 0x4 din=0x41 we=0xF, ack[0] in cycle 7, tout=0.
REQ-037 Loader rx, UART returns byte 0x33 -> ack[1] with rdata=0x33 in cycle 7.
REQ-038 Both req in same IDLE cycle twice in a row -> grants core then loader; next tie -> core.
REQ-039 Tx with stat tx_full=1 forever, POLL_LIMIT=4 -> 4 stat reads, no 0x4 write, ack with tout=1.
REQ-040 Rst asserted in XWAIT -> no ack, INIT repeats; uart_err pulse earlier -> err_o 1 until reset.
